div_seq_ctrl: RTL and testbench

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequences one div/mod instruction from EXE through an
// external divider core over a valid/ready operand channel and a valid-only
// result channel. It holds the selected quotient or remainder until EXE
// consumes it, and it drains in-flight core results when EXE flushes.
// Optional build macro: DIV_ZERO_FAST_EN. When this macro is defined, a zero
// divisor is resolved locally in a single cycle and the core is not issued.
module div_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,        // one-hot {div_w, mod_w, div_wu, mod_wu}
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        req_cancel,
  input  logic        res_ack,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        div_s_valid,
  input  logic        div_s_ready,
  output logic        div_signed,
  output logic [31:0] div_src1,
  output logic [31:0] div_src2,
  input  logic        div_m_valid,
  input  logic [63:0] div_m_data     // {quotient, remainder}
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] src1_reg;
  logic [31:0] src2_reg;
  logic [3:0]  op_reg;
  // A flush that lands while the operand handshake is still pending must be
  // remembered, because the core will still produce a result to be drained.
  logic        cancel_pend_reg;

  logic req_take;
  logic lat_is_div;

  assign req_take   = req_valid & ~req_cancel & (|req_op);
  assign lat_is_div = op_reg[3] | op_reg[1];

  // Operands reach the core straight from the latched registers, so they
  // cannot move while div_s_valid is high.
  assign div_src1   = src1_reg;
  assign div_src2   = src2_reg;
  assign div_signed = op_reg[3] | op_reg[2];

`ifdef DIV_ZERO_FAST_EN
  logic req_is_div;
  assign req_is_div = req_op[3] | req_op[1];
`endif

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      src1_reg        <= '0;
      src2_reg        <= '0;
      op_reg          <= '0;
      cancel_pend_reg <= 1'b0;
      div_s_valid     <= 1'b0;
      res_valid       <= 1'b0;
      res_data        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_take) begin
            src1_reg        <= req_src1;
            src2_reg        <= req_src2;
            op_reg          <= req_op;
            cancel_pend_reg <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            if (req_src2 == 32'd0) begin
              // Divide-by-zero: all-ones quotient, remainder = dividend.
              res_data  <= req_is_div ? 32'hFFFF_FFFF : req_src1;
              res_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              div_s_valid <= 1'b1;
              state_reg   <= SEND;
            end
`else
            div_s_valid <= 1'b1;
            state_reg   <= SEND;
`endif
          end
        end

        SEND: begin
          if (div_s_ready) begin
            div_s_valid     <= 1'b0;
            cancel_pend_reg <= 1'b0;
            state_reg       <= (cancel_pend_reg | req_cancel) ? DRAIN : WAIT;
          end else if (req_cancel) begin
            cancel_pend_reg <= 1'b1;
          end
        end

        WAIT: begin
          if (div_m_valid) begin
            if (req_cancel) begin
              // Flush coincides with the result: nothing left to drain.
              state_reg <= IDLE;
            end else begin
              res_data  <= lat_is_div ? div_m_data[63:32] : div_m_data[31:0];
              res_valid <= 1'b1;
              state_reg <= DONE;
            end
          end else if (req_cancel) begin
            state_reg <= DRAIN;
          end
        end

        DONE: begin
          if (res_ack | req_cancel) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        DRAIN: begin
          if (div_m_valid) begin
            state_reg <= IDLE;
          end
        end

        default: begin
          div_s_valid <= 1'b0;
          res_valid   <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: the stimulus thread plays EXE and the
// divider core with directed vectors, pushing each expected result (and the
// cycle it must appear in) into a queue; a negedge monitor pops and compares.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        req_cancel = 1'b0;
  logic        res_ack = 1'b0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        div_s_valid;
  logic        div_s_ready = 1'b0;
  logic        div_signed;
  logic [31:0] div_src1;
  logic [31:0] div_src2;
  logic        div_m_valid = 1'b0;
  logic [63:0] div_m_data = '0;

  localparam logic [3:0] OP_DIV_W  = 4'b1000;
  localparam logic [3:0] OP_MOD_W  = 4'b0100;
  localparam logic [3:0] OP_DIV_WU = 4'b0010;
  localparam logic [3:0] OP_MOD_WU = 4'b0001;

  typedef struct {
    logic [31:0] data;
    int          cyc;   // required arrival cycle, -1 when not checked
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  div_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_src1    (req_src1),
    .req_src2    (req_src2),
    .req_cancel  (req_cancel),
    .res_ack     (res_ack),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .div_s_valid (div_s_valid),
    .div_s_ready (div_s_ready),
    .div_signed  (div_signed),
    .div_src1    (div_src1),
    .div_src2    (div_src2),
    .div_m_valid (div_m_valid),
    .div_m_data  (div_m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: result arrival, result stability while held, operand stability.
  logic        prev_rv = 1'b0;
  logic [31:0] prev_rd = '0;
  logic        prev_sv = 1'b0;
  logic [64:0] prev_ops = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_rv = 1'b0;
      prev_sv = 1'b0;
    end else begin
      if (res_valid && !prev_rv) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result: got %h at cycle %0d expected no result", res_data, cycle);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("RESULT cycle=%0d data=%h expected=%h", cycle, res_data, e.data);
          if (res_data !== e.data) begin
            failures++;
            $display("FAIL result_data: got %h expected %h", res_data, e.data);
          end
          if (e.cyc >= 0) begin
            checks++;
            if (cycle != e.cyc) begin
              failures++;
              $display("FAIL result_latency: got cycle %0d expected cycle %0d", cycle, e.cyc);
            end
          end
        end
      end else if (res_valid && prev_rv) begin
        checks++;
        if (res_data !== prev_rd) begin
          failures++;
          $display("FAIL result_stable: got %h expected %h", res_data, prev_rd);
        end
      end
      if (div_s_valid && prev_sv) begin
        checks++;
        if ({div_signed, div_src1, div_src2} !== prev_ops) begin
          failures++;
          $display("FAIL operand_stable: got %h expected %h", {div_signed, div_src1, div_src2}, prev_ops);
        end
      end
      prev_rv  = res_valid;
      prev_rd  = res_data;
      prev_sv  = div_s_valid;
      prev_ops = {div_signed, div_src1, div_src2};
    end
  end

  // One full transaction. rdy_wait: cycles div_s_ready stays low in SEND;
  // m_wait: idle WAIT cycles; ack_wait: DONE cycles before release;
  // end_mode: 0 ack, 1 cancel, 2 ack+cancel.
  task automatic run_op(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                        input int rdy_wait, input int m_wait, input logic [63:0] mdata,
                        input int ack_wait, input int end_mode, input logic [31:0] exp);
    int   t0;
    int   sv_cnt;
    exp_t e;
    step();
    req_valid = 1'b1; req_op = op; req_src1 = s1; req_src2 = s2;
    t0 = cycle;
    e.data = exp; e.cyc = t0 + 3 + rdy_wait + m_wait;
    sb_q.push_back(e);
    step();
    chk("send_signed", {63'd0, div_signed}, {63'd0, (op[3] | op[2])});
    chk("send_src1", {32'd0, div_src1}, {32'd0, s1});
    chk("send_src2", {32'd0, div_src2}, {32'd0, s2});
    // Junk request while busy must not be latched.
    req_op = OP_DIV_WU; req_src1 = 32'h5555_5555; req_src2 = 32'h0000_0003;
    req_valid = (rdy_wait > 0);
    sv_cnt = 0;
    for (int i = 0; i < rdy_wait; i++) begin
      if (div_s_valid) sv_cnt++;
      step();
    end
    req_valid = 1'b0;
    if (div_s_valid) sv_cnt++;
    div_s_ready = 1'b1;
    step();
    div_s_ready = 1'b0;
    chk("s_valid_cycles", 64'(sv_cnt), 64'(rdy_wait + 1));
    chk("s_valid_drop", {63'd0, div_s_valid}, 64'd0);
    for (int i = 0; i < m_wait; i++) step();
    div_m_valid = 1'b1; div_m_data = mdata;
    step();
    div_m_valid = 1'b0;
    chk("res_valid_rise", {63'd0, res_valid}, 64'd1);
    for (int i = 0; i < ack_wait; i++) begin
      // Stray core results in DONE must not disturb the held result.
      div_m_valid = 1'b1; div_m_data = 64'hDEAD_BEEF_0BAD_F00D;
      step();
      chk("res_valid_hold", {63'd0, res_valid}, 64'd1);
    end
    div_m_valid = 1'b0;
    res_ack    = (end_mode != 1);
    req_cancel = (end_mode != 0);
    req_valid = 1'b1; req_op = OP_DIV_W; req_src1 = 32'h5555_5555; req_src2 = 32'h3;
    step();
    res_ack = 1'b0; req_cancel = 1'b0; req_valid = 1'b0;
    chk("release_idle", {63'd0, res_valid}, 64'd0);
    chk("no_accept_on_ack", {63'd0, div_s_valid}, 64'd0);
  endtask

  initial begin
    repeat (3) step();
    reset = 1'b0;
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_s_valid", {63'd0, div_s_valid}, 64'd0);
    chk("rst_res_data", {32'd0, res_data}, 64'd0);
    chk("rst_src1", {32'd0, div_src1}, 64'd0);
    chk("rst_src2", {32'd0, div_src2}, 64'd0);
    chk("rst_signed", {63'd0, div_signed}, 64'd0);

    // -7 / 2 signed, minimum latency.
    run_op(OP_DIV_W, 32'hFFFF_FFF9, 32'd2, 0, 0, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 0, 0, 32'hFFFF_FFFD);
    // 100 % 7 unsigned with ready held low 5 cycles.
    run_op(OP_MOD_WU, 32'd100, 32'd7, 5, 0, {32'd14, 32'd2}, 0, 0, 32'd2);
    // Result held 4 cycles before ack.
    run_op(OP_DIV_WU, 32'd1000, 32'd10, 1, 2, {32'd100, 32'd0}, 4, 0, 32'd100);

    // Cancel in WAIT, result arrives 10 cycles later and is drained.
    step();
    req_valid = 1'b1; req_op = OP_DIV_WU; req_src1 = 32'd50; req_src2 = 32'd5;
    step();
    req_valid = 1'b0; div_s_ready = 1'b1;
    step();
    div_s_ready = 1'b0; req_cancel = 1'b1;
    step();
    req_cancel = 1'b0;
    req_valid = 1'b1; req_op = OP_DIV_W; req_src1 = 32'd77; req_src2 = 32'd7;
    for (int i = 0; i < 9; i++) step();
    chk("drain_no_res", {63'd0, res_valid}, 64'd0);
    chk("drain_no_issue", {63'd0, div_s_valid}, 64'd0);
    req_valid = 1'b0;
    div_m_valid = 1'b1; div_m_data = {32'd10, 32'd0};
    step();
    div_m_valid = 1'b0;
    chk("drain_exit_res", {63'd0, res_valid}, 64'd0);
    step();
    chk("drain_idle_res", {63'd0, res_valid}, 64'd0);
    run_op(OP_DIV_W, 32'd9, 32'd3, 0, 0, {32'd3, 32'd0}, 0, 0, 32'd3);

    // Cancel in SEND: handshake still completes, then drain.
    step();
    req_valid = 1'b1; req_op = OP_MOD_W; req_src1 = 32'd20; req_src2 = 32'd6;
    step();
    req_valid = 1'b0; req_cancel = 1'b1;
    step();
    req_cancel = 1'b0;
    chk("cancel_send_hold", {63'd0, div_s_valid}, 64'd1);
    div_s_ready = 1'b1;
    step();
    div_s_ready = 1'b0;
    chk("cancel_send_done", {63'd0, div_s_valid}, 64'd0);
    div_m_valid = 1'b1; div_m_data = {32'd3, 32'd2};
    step();
    div_m_valid = 1'b0;
    chk("cancel_send_nores", {63'd0, res_valid}, 64'd0);
    step();
    chk("cancel_send_idle", {63'd0, res_valid}, 64'd0);

    // Cancel in DONE, then cancel together with ack.
    run_op(OP_MOD_W, 32'hFFFF_FFF9, 32'd2, 0, 1, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1, 1, 32'hFFFF_FFFF);
    run_op(OP_DIV_WU, 32'hFFFF_FFFF, 32'h10, 2, 0, {32'h0FFF_FFFF, 32'hF}, 0, 2, 32'h0FFF_FFFF);

    // Stray core result while IDLE.
    step();
    div_m_valid = 1'b1; div_m_data = {32'h1111_1111, 32'h2222_2222};
    step();
    div_m_valid = 1'b0;
    chk("stray_idle_res", {63'd0, res_valid}, 64'd0);
    chk("stray_idle_data", {32'd0, res_data}, {32'd0, 32'h0FFF_FFFF});

    // Divide by zero.
`ifdef DIV_ZERO_FAST_EN
    begin
      exp_t e;
      step();
      req_valid = 1'b1; req_op = OP_DIV_W; req_src1 = 32'd5; req_src2 = 32'd0;
      e.data = 32'hFFFF_FFFF; e.cyc = cycle + 1; sb_q.push_back(e);
      step();
      req_valid = 1'b0;
      chk("dz_div_no_issue", {63'd0, div_s_valid}, 64'd0);
      chk("dz_div_res_valid", {63'd0, res_valid}, 64'd1);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      req_valid = 1'b1; req_op = OP_MOD_W; req_src1 = 32'd5; req_src2 = 32'd0;
      e.data = 32'd5; e.cyc = cycle + 1; sb_q.push_back(e);
      step();
      req_valid = 1'b0;
      chk("dz_mod_no_issue", {63'd0, div_s_valid}, 64'd0);
      chk("dz_mod_res_valid", {63'd0, res_valid}, 64'd1);
      res_ack = 1'b1;
      step();
      res_ack = 1'b0;
      chk("dz_mod_release", {63'd0, res_valid}, 64'd0);
    end
`else
    run_op(OP_DIV_W, 32'd5, 32'd0, 0, 0, {32'hCAFE_0001, 32'hCAFE_0002}, 0, 0, 32'hCAFE_0001);
    run_op(OP_MOD_W, 32'd5, 32'd0, 0, 0, {32'hCAFE_0001, 32'hCAFE_0002}, 0, 0, 32'hCAFE_0002);
`endif

    // Reset while in WAIT aborts without drain.
    step();
    req_valid = 1'b1; req_op = OP_DIV_W; req_src1 = 32'd40; req_src2 = 32'd8;
    step();
    req_valid = 1'b0; div_s_ready = 1'b1;
    step();
    div_s_ready = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("wait_rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("wait_rst_s_valid", {63'd0, div_s_valid}, 64'd0);
    chk("wait_rst_res_data", {32'd0, res_data}, 64'd0);
    chk("wait_rst_src1", {32'd0, div_src1}, 64'd0);
    div_m_valid = 1'b1; div_m_data = {32'd5, 32'd0};
    step();
    div_m_valid = 1'b0;
    chk("wait_rst_stray", {63'd0, res_valid}, 64'd0);
    step();
    chk("wait_rst_idle", {63'd0, res_valid}, 64'd0);
    run_op(OP_DIV_W, 32'd40, 32'd8, 0, 0, {32'd5, 32'd0}, 0, 0, 32'd5);

    step();
    step();
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
